// File: rtl/pcm_rom_fetch_pkg.sv
// Shared types and helpers for the PCM sample-ROM fetch arbiter.
// A line is one 64-bit DDRAM word holding eight consecutive ROM bytes.
package pcm_rom_fetch_pkg;

    localparam int LINE_BYTES = 8;
    localparam int LINE_W     = 64;

    typedef enum logic {
        IDLE,
        WAIT
    } fsm_state_t;

    // Byte 0 sits in bits 7:0 of the line.
    function automatic logic [7:0] byte_sel(input logic [LINE_W-1:0] line,
                                            input logic [2:0]        off);
        return line[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pcm_rom_fetch_arb_line_buf.sv
// One-line sample buffer for a single requester.
// It holds the tag, valid bit and line data, and provides the hit compare and byte mux.
module line_buf
    import pcm_rom_fetch_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    input  logic              fill,
    input  logic              fill_valid,
    input  logic [ADDR_W-4:0] fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic [ADDR_W-1:0] look_addr,
    output logic              hit,
    output logic [7:0]        look_byte
);

    logic              valid;
    logic [ADDR_W-4:0] tag;
    logic [LINE_W-1:0] line;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid <= fill_valid;
            end
            if (fill) begin
                tag  <= fill_tag;
                line <= fill_line;
            end
        end
    end

    // A flush in the same cycle as a strobe forces that strobe to miss.
    assign hit       = valid && !flush && (tag == look_addr[ADDR_W-1:3]);
    assign look_byte = byte_sel(line, look_addr[2:0]);

endmodule

// File: rtl/pcm_rom_fetch_arb.sv
// Shares one 64-bit DDRAM read channel between two byte-wide sample-ROM requesters.
// Each requester has its own line buffer; misses are arbitrated round-robin and identical misses are coalesced.
module pcm_rom_fetch_arb
    import pcm_rom_fetch_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_rd,
    output logic [7:0]        req0_data,
    output logic              req0_rdy,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_rd,
    output logic [7:0]        req1_data,
    output logic              req1_rdy,
    output logic [ADDR_W-4:0] mem_addr,
    output logic              mem_req,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_ready
);

    localparam int LA_W = ADDR_W - 3;

    fsm_state_t        state, state_nxt;
    logic [1:0]        rd_v, pend, hit, fill, rdy_q;
    logic [ADDR_W-1:0] rd_addr  [2];
    logic [ADDR_W-1:0] lat      [2];
    logic [7:0]        hit_byte [2];
    logic [7:0]        data_q   [2];
    logic              rr_ptr, grant, flushed, fill_valid;
    logic [LA_W-1:0]   addr_q;

    assign rd_v       = {req1_rd, req0_rd};
    assign rd_addr[0] = req0_addr;
    assign rd_addr[1] = req1_addr;
    assign req0_rdy   = rdy_q[0];
    assign req1_rdy   = rdy_q[1];
    assign req0_data  = data_q[0];
    assign req1_data  = data_q[1];
    assign fill_valid = !(flush || flushed);

    for (genvar g = 0; g < 2; g++) begin : g_buf
        line_buf #(.ADDR_W(ADDR_W)) u_buf (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .flush      (flush),
            .fill       (fill[g]),
            .fill_valid (fill_valid),
            .fill_tag   (addr_q),
            .fill_line  (mem_data),
            .look_addr  (rd_addr[g]),
            .hit        (hit[g]),
            .look_byte  (hit_byte[g])
        );
    end

    // Filling every pending requester whose line matches covers both the grantee and a coalesced partner.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = addr_q;
        grant     = 1'b0;
        fill      = '0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    mem_req   = 1'b1;
                    grant     = (&pend) ? ~rr_ptr : pend[1];
                    mem_addr  = lat[grant][ADDR_W-1:3];
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    for (int k = 0; k < 2; k++) begin
                        fill[k] = pend[k] && (lat[k][ADDR_W-1:3] == addr_q);
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            lat[0]    <= '0;
            lat[1]    <= '0;
            rr_ptr    <= 1'b1;
            addr_q    <= '0;
            flushed   <= 1'b0;
            rdy_q     <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            state <= state_nxt;
            if (mem_req) begin
                addr_q  <= mem_addr;
                flushed <= 1'b0;
                if (&pend) begin
                    rr_ptr <= grant;
                end
            end else if (state == WAIT && flush) begin
                flushed <= 1'b1;
            end
            // A strobe while pending is dropped; fill only ever targets pending requesters.
            for (int k = 0; k < 2; k++) begin
                rdy_q[k] <= 1'b0;
                if (rd_v[k] && !pend[k]) begin
                    lat[k] <= rd_addr[k];
                    if (hit[k]) begin
                        rdy_q[k]  <= 1'b1;
                        data_q[k] <= hit_byte[k];
                    end else begin
                        pend[k] <= 1'b1;
                    end
                end else if (fill[k]) begin
                    pend[k]   <= 1'b0;
                    rdy_q[k]  <= 1'b1;
                    data_q[k] <= byte_sel(mem_data, lat[k][2:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_rom_fetch_arb.sv
// Self-checking bench for pcm_rom_fetch_arb.
// It runs directed scenario tasks and then a randomized run checked against a requester-level reference model.
module tb_pcm_rom_fetch_arb;

    localparam int ADDR_W = 18;
    localparam int LA_W   = ADDR_W - 3;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              flush;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_rd, req1_rd;
    logic [7:0]        req0_data, req1_data;
    logic              req0_rdy, req1_rdy;
    logic [LA_W-1:0]   mem_addr;
    logic              mem_req;
    logic [63:0]       mem_data;
    logic              mem_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    pcm_rom_fetch_arb #(.ADDR_W(ADDR_W)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .flush     (flush),
        .req0_addr (req0_addr),
        .req0_rd   (req0_rd),
        .req0_data (req0_data),
        .req0_rdy  (req0_rdy),
        .req1_addr (req1_addr),
        .req1_rd   (req1_rd),
        .req1_data (req1_data),
        .req1_rdy  (req1_rdy),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_data  (mem_data),
        .mem_ready (mem_ready)
    );

    // Contents of the simulated DDRAM: a fixed scramble of the line address.
    function automatic logic [63:0] line_image(input logic [LA_W-1:0] la);
        logic [63:0] x;
        x = {{(64-LA_W){1'b0}}, la};
        return (x * 64'h9E3779B97F4A7C15) ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [63:0] l, input logic [2:0] o);
        return 8'(l >> (8 * o));
    endfunction

    task automatic clear_inputs();
        flush     = 1'b0;
        req0_rd   = 1'b0;
        req1_rd   = 1'b0;
        req0_addr = '0;
        req1_addr = '0;
        mem_ready = 1'b0;
        mem_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_sys);
            vectors++;
            if ({req0_rdy, req1_rdy, mem_req} !== 3'b000 || req0_data !== 8'h00 ||
                req1_data !== 8'h00 || mem_addr !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold: got rdy0=%b rdy1=%b req=%b d0=%h d1=%h addr=%h expected all zero",
                         req0_rdy, req1_rdy, mem_req, req0_data, req1_data, mem_addr);
            end
            req0_addr = ADDR_W'($urandom);
            req1_addr = ADDR_W'($urandom);
            req0_rd   = 1'($urandom);
            req1_rd   = 1'($urandom);
            flush     = 1'($urandom);
            mem_ready = 1'($urandom);
            mem_data  = {$urandom, $urandom};
        end
        @(negedge clk_sys);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk_sys);
        vectors++;
        if ({req0_rdy, req1_rdy, mem_req} !== 3'b000 || req0_data !== 8'h00 ||
            req1_data !== 8'h00 || mem_addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got rdy0=%b rdy1=%b req=%b d0=%h d1=%h addr=%h expected all zero",
                     req0_rdy, req1_rdy, mem_req, req0_data, req1_data, mem_addr);
        end
        req0_addr = 18'h00010;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0002) begin
            miscompares++;
            $display("[TB] FAIL reset_first_miss: got req=%b addr=%h expected req=1 addr=0002", mem_req, mem_addr);
        end
    endtask

    task automatic test_miss_then_hit();
        do_reset();
        req0_addr = 18'h00013;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0002) begin
            miscompares++;
            $display("[TB] FAIL mth_issue: got req=%b addr=%h expected req=1 addr=0002", mem_req, mem_addr);
        end
        @(negedge clk_sys);
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 15'h0002 || req0_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mth_wait_hold: got req=%b addr=%h rdy0=%b expected req=0 addr=0002 rdy0=0",
                     mem_req, mem_addr, req0_rdy);
        end
        mem_ready = 1'b1;
        mem_data  = 64'h8877665544332211;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        mem_data  = '0;
        vectors++;
        if (req0_rdy !== 1'b1 || req0_data !== 8'h44) begin
            miscompares++;
            $display("[TB] FAIL mth_fill: got rdy0=%b data=%h expected rdy0=1 data=44", req0_rdy, req0_data);
        end
        req0_addr = 18'h00016;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        vectors++;
        if (req0_rdy !== 1'b1 || req0_data !== 8'h77 || mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mth_hit: got rdy0=%b data=%h req=%b expected rdy0=1 data=77 req=0",
                     req0_rdy, req0_data, mem_req);
        end
        @(negedge clk_sys);
        vectors++;
        if (req0_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mth_rdy_pulse: got rdy0=%b expected 0", req0_rdy);
        end
    endtask

    task automatic test_round_robin();
        logic [LA_W-1:0] first_line  [2];
        logic [LA_W-1:0] second_line [2];
        logic [ADDR_W-1:0] a0 [2];
        logic [ADDR_W-1:0] a1 [2];
        a0[0] = 18'h00100; a1[0] = 18'h00200;
        a0[1] = 18'h00300; a1[1] = 18'h00400;
        first_line[0]  = 15'h0020; second_line[0] = 15'h0040;
        first_line[1]  = 15'h0080; second_line[1] = 15'h0060;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            req0_addr = a0[p];
            req1_addr = a1[p];
            req0_rd   = 1'b1;
            req1_rd   = 1'b1;
            @(negedge clk_sys);
            req0_rd = 1'b0;
            req1_rd = 1'b0;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== first_line[p]) begin
                miscompares++;
                $display("[TB] FAIL rr_first_%0d: got req=%b addr=%h expected req=1 addr=%h",
                         p, mem_req, mem_addr, first_line[p]);
            end
            @(negedge clk_sys);
            mem_ready = 1'b1;
            mem_data  = line_image(first_line[p]);
            @(negedge clk_sys);
            mem_ready = 1'b0;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== second_line[p]) begin
                miscompares++;
                $display("[TB] FAIL rr_second_%0d: got req=%b addr=%h expected req=1 addr=%h",
                         p, mem_req, mem_addr, second_line[p]);
            end
            @(negedge clk_sys);
            mem_ready = 1'b1;
            mem_data  = line_image(second_line[p]);
            @(negedge clk_sys);
            mem_ready = 1'b0;
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        req0_addr = 18'h00281;
        req1_addr = 18'h00286;
        req0_rd   = 1'b1;
        req1_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        req1_rd = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0050) begin
            miscompares++;
            $display("[TB] FAIL coal_issue: got req=%b addr=%h expected req=1 addr=0050", mem_req, mem_addr);
        end
        @(negedge clk_sys);
        mem_ready = 1'b1;
        mem_data  = 64'h8877665544332211;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        vectors++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b1 || req0_data !== 8'h22 || req1_data !== 8'h77) begin
            miscompares++;
            $display("[TB] FAIL coal_both_rdy: got rdy0=%b rdy1=%b d0=%h d1=%h expected 1 1 22 77",
                     req0_rdy, req1_rdy, req0_data, req1_data);
        end
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (mem_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL coal_single_req: got req=%b expected 0", mem_req);
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        d = 64'hF0E0D0C0B0A09080;
        do_reset();
        req0_addr = 18'h00013;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        @(negedge clk_sys);
        flush = 1'b1;
        @(negedge clk_sys);
        flush     = 1'b0;
        mem_ready = 1'b1;
        mem_data  = d;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        vectors++;
        if (req0_rdy !== 1'b1 || req0_data !== 8'hB0) begin
            miscompares++;
            $display("[TB] FAIL flush_inflight_data: got rdy0=%b data=%h expected rdy0=1 data=b0", req0_rdy, req0_data);
        end
        req0_addr = 18'h00015;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0002 || req0_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_reread: got req=%b addr=%h rdy0=%b expected req=1 addr=0002 rdy0=0",
                     mem_req, mem_addr, req0_rdy);
        end
        @(negedge clk_sys);
        mem_ready = 1'b1;
        mem_data  = d;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        req0_addr = 18'h00011;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (req0_rdy !== 1'b1 || req0_data !== 8'h90) begin
            miscompares++;
            $display("[TB] FAIL flush_refill_hit: got rdy0=%b data=%h expected rdy0=1 data=90", req0_rdy, req0_data);
        end
        req0_addr = 18'h00012;
        flush     = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        flush   = 1'b0;
        vectors++;
        if (req0_rdy !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 15'h0002) begin
            miscompares++;
            $display("[TB] FAIL flush_vs_hit: got rdy0=%b req=%b addr=%h expected rdy0=0 req=1 addr=0002",
                     req0_rdy, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req0_addr = 18'h00013;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        mem_ready = 1'b1;
        mem_data  = 64'h1122334455667788;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        vectors++;
        if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_wait_stale_ready: got rdy0=%b rdy1=%b req=%b expected 0 0 0",
                     req0_rdy, req1_rdy, mem_req);
        end
        req0_addr = 18'h00020;
        req0_rd   = 1'b1;
        @(negedge clk_sys);
        req0_rd = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0004) begin
            miscompares++;
            $display("[TB] FAIL rst_wait_fresh: got req=%b addr=%h expected req=1 addr=0004", mem_req, mem_addr);
        end
    endtask

    task automatic test_random(input int n_cycles);
        logic              m_pend    [2];
        logic [LA_W-1:0]   m_pline   [2];
        logic [2:0]        m_poff    [2];
        logic              m_valid   [2];
        logic [LA_W-1:0]   m_bline   [2];
        logic              m_exp_rdy [2];
        logic [7:0]        m_exp_dat [2];
        logic              rd        [2];
        logic [ADDR_W-1:0] addr      [2];
        logic              hitv      [2];
        logic              acc       [2];
        logic              o_rdy     [2];
        logic [7:0]        o_data    [2];
        logic [LA_W-1:0]   pool      [4];
        logic              o_req, m_out, m_taint, was_out;
        logic [LA_W-1:0]   o_addr, m_oline, want;
        int                wait_left, grantee, last_tie;

        pool[0] = 15'h0002;
        pool[1] = 15'h7FFF;
        pool[2] = 15'h0050;
        pool[3] = LA_W'($urandom);
        for (int i = 0; i < 2; i++) begin
            m_pend[i]    = 1'b0;
            m_pline[i]   = '0;
            m_poff[i]    = '0;
            m_valid[i]   = 1'b0;
            m_bline[i]   = '0;
            m_exp_rdy[i] = 1'b0;
            m_exp_dat[i] = '0;
            addr[i]      = '0;
        end
        m_out     = 1'b0;
        m_taint   = 1'b0;
        m_oline   = '0;
        wait_left = 0;
        last_tie  = 1;
        do_reset();

        for (int c = 0; c < n_cycles; c++) begin
            o_req     = mem_req;
            o_addr    = mem_addr;
            o_rdy[0]  = req0_rdy;
            o_rdy[1]  = req1_rdy;
            o_data[0] = req0_data;
            o_data[1] = req1_data;

            for (int i = 0; i < 2; i++) begin
                rd[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 4) < 2) begin
                    addr[i] = {pool[$urandom_range(0, 3)], 3'($urandom)};
                end else begin
                    addr[i][2:0] = 3'($urandom);
                end
            end
            flush     = ($urandom_range(0, 19) == 0);
            mem_ready = 1'b0;
            mem_data  = {$urandom, $urandom};
            if (m_out) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_data  = line_image(m_oline);
                end else begin
                    wait_left--;
                end
            end
            req0_rd   = rd[0];
            req1_rd   = rd[1];
            req0_addr = addr[0];
            req1_addr = addr[1];

            // DDRAM request side: one request at a time, round robin among waiting requesters.
            was_out = m_out;
            if (!m_out && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) begin
                    grantee  = (last_tie == 1) ? 0 : 1;
                    last_tie = grantee;
                end else begin
                    grantee = m_pend[1] ? 1 : 0;
                end
                want = m_pline[grantee];
                vectors++;
                if (o_req !== 1'b1 || o_addr !== want) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_issue c=%0d: got req=%b addr=%h expected req=1 addr=%h",
                             c, o_req, o_addr, want);
                end
                m_out     = 1'b1;
                m_oline   = want;
                m_taint   = 1'b0;
                wait_left = $urandom_range(0, 3);
            end else begin
                vectors++;
                if (o_req !== 1'b0 || (m_out && o_addr !== m_oline)) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_no_issue c=%0d: got req=%b addr=%h expected req=0 (held addr=%h)",
                             c, o_req, o_addr, m_oline);
                end
            end

            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (o_rdy[i] !== m_exp_rdy[i] || (m_exp_rdy[i] && o_data[i] !== m_exp_dat[i])) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_rdy%0d c=%0d: got rdy=%b data=%h expected rdy=%b data=%h",
                             i, c, o_rdy[i], o_data[i], m_exp_rdy[i], m_exp_dat[i]);
                end
                m_exp_rdy[i] = 1'b0;
                acc[i]  = rd[i] && !m_pend[i];
                hitv[i] = acc[i] && m_valid[i] && !flush && (m_bline[i] == addr[i][ADDR_W-1:3]);
            end

            if (was_out && mem_ready) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_pend[i] && m_pline[i] == m_oline) begin
                        m_pend[i]    = 1'b0;
                        m_valid[i]   = !(m_taint || flush);
                        m_bline[i]   = m_oline;
                        m_exp_rdy[i] = 1'b1;
                        m_exp_dat[i] = pick_byte(line_image(m_oline), m_poff[i]);
                    end
                end
                m_out = 1'b0;
            end

            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (hitv[i]) begin
                        m_exp_rdy[i] = 1'b1;
                        m_exp_dat[i] = pick_byte(line_image(addr[i][ADDR_W-1:3]), addr[i][2:0]);
                    end else begin
                        m_pend[i]  = 1'b1;
                        m_pline[i] = addr[i][ADDR_W-1:3];
                        m_poff[i]  = addr[i][2:0];
                    end
                end
                if (flush) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (flush && was_out && m_out) begin
                m_taint = 1'b1;
            end

            @(negedge clk_sys);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_miss_then_hit();
        test_round_robin();
        test_coalesce();
        test_flush();
        test_reset_mid_wait();
        test_random(4000);
        repeat (2) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
